// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network output stages.
//   max_state_t  : scan FSM state encoding for max_finder
//   NUM_CLASSES  : default number of output-layer neurons (class count)
//   DATA_WIDTH   : default width of one neuron output
package nn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } max_state_t;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_WIDTH  = 8;

endpackage : nn_pkg

// File: rtl/max_compare.sv
// Combinational magnitude compare used by the argmax scan.
//   a, b      : operands, dataWidth bits
//   aGreater  : 1 when a > b (strict), two's-complement if isSigned else unsigned
module max_compare #(
  parameter int dataWidth = 8,
  parameter bit isSigned  = 1'b0
) (
  input  logic [dataWidth-1:0] a,
  input  logic [dataWidth-1:0] b,
  output logic                 aGreater
);

  always_comb begin
    if (isSigned) begin
      aGreater = ($signed(a) > $signed(b));
    end else begin
      aGreater = (a > b);
    end
  end

endmodule : max_compare

// File: rtl/max_finder.sv
// Output-layer argmax stage.
// Captures a flat vector of neuron outputs, scans it one element per clock
// and publishes the index/value of the largest element with a one-cycle pulse.
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active-low
//   dataIn        : numInputs*dataWidth, element i at dataIn[i*dataWidth +: dataWidth]
//   dataInValid   : vector present (accepted only when busy==0)
//   busy          : scan in progress (FSM in SCAN)
//   maxIndex      : index of the largest element of the last completed scan
//   maxValue      : value of the largest element of the last completed scan
//   dataOutValid  : one-cycle pulse when maxIndex/maxValue are updated
//   overrun       : sticky flag, a dataInValid arrived while busy and was dropped
//
// Handshake: there is no back-pressure. dataInValid is a one-cycle strobe that is
// accepted on any rising edge where busy==0; while busy==1 it is dropped and
// recorded in overrun. dataOutValid is a one-cycle strobe with no ready; the
// consumer must take maxIndex/maxValue in that cycle (they are held afterwards
// until the next result).
module max_finder
  import nn_pkg::*;
#(
  parameter int numInputs  = NUM_CLASSES,
  parameter int dataWidth  = DATA_WIDTH,
  parameter bit isSigned   = 1'b0,
  parameter int indexWidth = ($clog2(numInputs) > 1) ? $clog2(numInputs) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [numInputs*dataWidth-1:0] dataIn,
  input  logic                           dataInValid,
  output logic                           busy,
  output logic [indexWidth-1:0]          maxIndex,
  output logic [dataWidth-1:0]           maxValue,
  output logic                           dataOutValid,
  output logic                           overrun
);

  localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(numInputs - 1);
  localparam logic [indexWidth-1:0] ONE_IDX  = indexWidth'(1);

  max_state_t                     state_q, state_d;
  logic [numInputs*dataWidth-1:0] buf_q, buf_d;
  logic [dataWidth-1:0]           run_val_q, run_val_d;
  logic [indexWidth-1:0]          run_idx_q, run_idx_d;
  logic [indexWidth-1:0]          cnt_q, cnt_d;
  logic [indexWidth-1:0]          max_index_q, max_index_d;
  logic [dataWidth-1:0]           max_value_q, max_value_d;
  logic                           out_valid_q, out_valid_d;
  logic                           overrun_q, overrun_d;

  logic [dataWidth-1:0]           elem_cur;
  logic                           cur_greater;
  logic [dataWidth-1:0]           fin_val;
  logic [indexWidth-1:0]          fin_idx;

  // Element mux by cnt. The loop form avoids an out-of-range part-select
  // when numInputs is not a power of two.
  always_comb begin
    elem_cur = '0;
    for (int i = 0; i < numInputs; i++) begin
      if (cnt_q == indexWidth'(i)) begin
        elem_cur = buf_q[i*dataWidth +: dataWidth];
      end
    end
  end

  max_compare #(
    .dataWidth(dataWidth),
    .isSigned (isSigned)
  ) u_max_compare (
    .a       (elem_cur),
    .b       (run_val_q),
    .aGreater(cur_greater)
  );

  // Strictly greater replaces the running max, so ties keep the lower index.
  always_comb begin
    if (cur_greater) begin
      fin_val = elem_cur;
      fin_idx = cnt_q;
    end else begin
      fin_val = run_val_q;
      fin_idx = run_idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    run_val_d   = run_val_q;
    run_idx_d   = run_idx_q;
    cnt_d       = cnt_q;
    max_index_d = max_index_q;
    max_value_d = max_value_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (dataInValid) begin
          buf_d     = dataIn;
          run_val_d = dataIn[dataWidth-1:0];
          run_idx_d = '0;
          cnt_d     = ONE_IDX;
          if (numInputs == 1) begin
            // Single-element vector: the answer is known at capture.
            max_index_d = '0;
            max_value_d = dataIn[dataWidth-1:0];
            out_valid_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (dataInValid) begin
          overrun_d = 1'b1;
        end
        run_val_d = fin_val;
        run_idx_d = fin_idx;
        if (cnt_q == LAST_IDX) begin
          max_index_d = fin_idx;
          max_value_d = fin_val;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_IDX;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      run_val_q   <= '0;
      run_idx_q   <= '0;
      cnt_q       <= '0;
      max_index_q <= '0;
      max_value_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      run_val_q   <= run_val_d;
      run_idx_q   <= run_idx_d;
      cnt_q       <= cnt_d;
      max_index_q <= max_index_d;
      max_value_q <= max_value_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign maxIndex     = max_index_q;
  assign maxValue     = max_value_q;
  assign dataOutValid = out_valid_q;
  assign overrun      = overrun_q;

endmodule : max_finder

// File: tb/tb_max_finder.sv
// Bench for max_finder: three instances share clk/reset.
//   u_* : numInputs=10, unsigned
//   s_* : numInputs=10, signed (same stimulus as u_*)
//   n_* : numInputs=1, unsigned
module tb_max_finder;

  logic        clk;
  logic        reset;
  logic [79:0] data_in;
  logic        din_valid;
  logic [7:0]  n_din;
  logic        n_vin;

  logic        u_busy, u_ov, u_overrun;
  logic [3:0]  u_idx;
  logic [7:0]  u_val;
  logic        s_busy, s_ov, s_overrun;
  logic [3:0]  s_idx;
  logic [7:0]  s_val;
  logic        n_busy, n_ov, n_overrun;
  logic [0:0]  n_idx;
  logic [7:0]  n_val;

  int checks   = 0;
  int failures = 0;
  int lat;
  bit n_busy_seen = 1'b0;

  logic [11:0] exp_u_q[$];
  logic [11:0] exp_s_q[$];
  logic [7:0]  exp_n_q[$];
  logic [11:0] e_u, e_s;
  logic [7:0]  e_n;

  typedef struct {
    logic [79:0] data;
    logic [3:0]  u_idx;
    logic [7:0]  u_val;
    logic [3:0]  s_idx;
    logic [7:0]  s_val;
  } vec_t;

  vec_t tbl[9];

  max_finder #(.numInputs(10), .dataWidth(8), .isSigned(1'b0)) u_dut (
    .clk(clk), .reset(reset), .dataIn(data_in), .dataInValid(din_valid),
    .busy(u_busy), .maxIndex(u_idx), .maxValue(u_val),
    .dataOutValid(u_ov), .overrun(u_overrun)
  );

  max_finder #(.numInputs(10), .dataWidth(8), .isSigned(1'b1)) s_dut (
    .clk(clk), .reset(reset), .dataIn(data_in), .dataInValid(din_valid),
    .busy(s_busy), .maxIndex(s_idx), .maxValue(s_val),
    .dataOutValid(s_ov), .overrun(s_overrun)
  );

  max_finder #(.numInputs(1), .dataWidth(8), .isSigned(1'b0)) n_dut (
    .clk(clk), .reset(reset), .dataIn(n_din), .dataInValid(n_vin),
    .busy(n_busy), .maxIndex(n_idx), .maxValue(n_val),
    .dataOutValid(n_ov), .overrun(n_overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                     input logic [7:0] e2, input logic [7:0] e3,
                                     input logic [7:0] e4, input logic [7:0] e5,
                                     input logic [7:0] e6, input logic [7:0] e7,
                                     input logic [7:0] e8, input logic [7:0] e9);
    return {e9, e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // ---------------- driver tasks ----------------
  // Call at a negedge; returns at the negedge right after the capture edge,
  // with the input bus scrambled (the DUT must not rely on it any more).
  task automatic drive_capture(input logic [79:0] d);
    data_in   = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    data_in   = {16'($urandom()), $urandom(), $urandom()};
  endtask

  // lat counts capture edge as 1; returns at the negedge where u_ov is high.
  task automatic wait_result(input int start, output int l);
    l = start;
    while (!u_ov && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (!u_ov) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=none required=dataOutValid");
    end
  endtask

  task automatic push_exp(input int i);
    exp_u_q.push_back({tbl[i].u_idx, tbl[i].u_val});
    exp_s_q.push_back({tbl[i].s_idx, tbl[i].s_val});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (n_busy) n_busy_seen = 1'b1;
    if (u_ov) begin
      if (exp_u_q.size() == 0) begin
        chk("u_unexpected_pulse", 32'(u_ov), 32'd0);
      end else begin
        e_u = exp_u_q.pop_front();
        chk("u_index", 32'(u_idx), 32'(e_u[11:8]));
        chk("u_value", 32'(u_val), 32'(e_u[7:0]));
      end
    end
    if (s_ov) begin
      if (exp_s_q.size() == 0) begin
        chk("s_unexpected_pulse", 32'(s_ov), 32'd0);
      end else begin
        e_s = exp_s_q.pop_front();
        chk("s_index", 32'(s_idx), 32'(e_s[11:8]));
        chk("s_value", 32'(s_val), 32'(e_s[7:0]));
      end
    end
    if (n_ov) begin
      if (exp_n_q.size() == 0) begin
        chk("n_unexpected_pulse", 32'(n_ov), 32'd0);
      end else begin
        e_n = exp_n_q.pop_front();
        chk("n_index", 32'(n_idx), 32'd0);
        chk("n_value", 32'(n_val), 32'(e_n));
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    data_in   = '0;
    n_vin     = 1'b0;
    n_din     = '0;

    //            data                                                   u_idx u_val  s_idx s_val
    tbl[0] = '{pk(0, 3, 7, 2, 9, 1, 9, 4, 0, 5),                          4'd4, 8'd9,  4'd4, 8'd9};
    tbl[1] = '{pk(8'hFF, 8'h80, 8'hFD, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE),
                                                                          4'd0, 8'hFF, 4'd0, 8'hFF};
    tbl[2] = '{pk(8'h01, 8'h80, 8'h7F, 0, 0, 0, 0, 0, 0, 0),              4'd1, 8'h80, 4'd2, 8'h7F};
    tbl[3] = '{pk(10, 20, 30, 40, 50, 60, 70, 80, 90, 255),               4'd9, 8'd255, 4'd8, 8'd90};
    tbl[4] = '{pk(42, 42, 42, 42, 42, 42, 42, 42, 42, 42),                4'd0, 8'd42, 4'd0, 8'd42};
    tbl[5] = '{pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 200),                        4'd9, 8'd200, 4'd0, 8'd0};
    tbl[6] = '{pk(9, 8, 7, 6, 5, 4, 3, 2, 1, 0),                          4'd0, 8'd9,  4'd0, 8'd9};
    tbl[7] = '{pk(5, 5, 5, 7, 5, 7, 5, 5, 5, 5),                          4'd3, 8'd7,  4'd3, 8'd7};
    tbl[8] = '{pk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h81),
                                                                          4'd9, 8'h81, 4'd9, 8'h81};

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_u_idx", 32'(u_idx), 32'd0);
    chk("rst_u_val", 32'(u_val), 32'd0);
    chk("rst_u_ov", 32'(u_ov), 32'd0);
    chk("rst_u_busy", 32'(u_busy), 32'd0);
    chk("rst_u_overrun", 32'(u_overrun), 32'd0);
    chk("rst_n_val", 32'(n_val), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven vectors, both 10-element instances in lockstep.
    for (int i = 0; i < 9; i++) begin
      push_exp(i);
      drive_capture(tbl[i].data);
      chk("busy_after_capture", 32'(u_busy), 32'd1);
      wait_result(1, lat);
      chk("latency", 32'(lat), 32'd10);
      chk("busy_at_result", 32'(u_busy), 32'd0);
      chk("s_valid_aligned", 32'(s_ov), 32'd1);
      @(negedge clk);
      chk("valid_self_clear", 32'(u_ov), 32'd0);
      chk("u_value_hold", 32'(u_val), 32'(tbl[i].u_val));
      chk("s_index_hold", 32'(s_idx), 32'(tbl[i].s_idx));
    end

    // Back-to-back: second vector offered in the dataOutValid cycle.
    push_exp(0);
    drive_capture(tbl[0].data);
    wait_result(1, lat);
    push_exp(5);
    drive_capture(tbl[5].data);
    chk("b2b_accepted_busy", 32'(u_busy), 32'd1);
    wait_result(1, lat);
    chk("b2b_latency", 32'(lat), 32'd10);
    chk("b2b_overrun", 32'(u_overrun), 32'd0);
    @(negedge clk);

    // Overrun: extra strobe at scan clock 3 is dropped.
    push_exp(0);
    drive_capture(tbl[0].data);
    @(negedge clk);
    data_in   = tbl[3].data;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("overrun_set", 32'(u_overrun), 32'd1);
    wait_result(3, lat);
    chk("overrun_latency", 32'(lat), 32'd10);
    repeat (15) @(negedge clk);
    chk("overrun_sticky", 32'(u_overrun), 32'd1);
    chk("s_overrun_sticky", 32'(s_overrun), 32'd1);
    chk("overrun_no_new_scan", 32'(u_busy), 32'd0);

    // Reset mid-scan at clock 4: outputs clear at once, no pulse afterwards.
    drive_capture(tbl[6].data);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_u_idx", 32'(u_idx), 32'd0);
    chk("midrst_u_val", 32'(u_val), 32'd0);
    chk("midrst_u_ov", 32'(u_ov), 32'd0);
    chk("midrst_u_busy", 32'(u_busy), 32'd0);
    chk("midrst_u_overrun", 32'(u_overrun), 32'd0);
    chk("midrst_s_val", 32'(s_val), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_publish", 32'(u_val), 32'd0);

    push_exp(3);
    drive_capture(tbl[3].data);
    wait_result(1, lat);
    chk("post_rst_latency", 32'(lat), 32'd10);
    @(negedge clk);

    // numInputs=1: result one clock after capture, back-to-back every clock.
    exp_n_q.push_back(8'h37);
    n_din = 8'h37;
    n_vin = 1'b1;
    @(negedge clk);
    n_vin = 1'b0;
    chk("n1_valid_next_clock", 32'(n_ov), 32'd1);
    @(negedge clk);
    chk("n1_valid_self_clear", 32'(n_ov), 32'd0);
    exp_n_q.push_back(8'hA5);
    exp_n_q.push_back(8'h5A);
    n_din = 8'hA5;
    n_vin = 1'b1;
    @(negedge clk);
    n_din = 8'h5A;
    chk("n1_b2b_first", 32'(n_ov), 32'd1);
    @(negedge clk);
    n_vin = 1'b0;
    chk("n1_b2b_second", 32'(n_ov), 32'd1);
    @(negedge clk);
    chk("n1_busy_never", 32'(n_busy_seen), 32'd0);
    chk("n1_overrun", 32'(n_overrun), 32'd0);

    chk("u_queue_drained", 32'(exp_u_q.size()), 32'd0);
    chk("s_queue_drained", 32'(exp_s_q.size()), 32'd0);
    chk("n_queue_drained", 32'(exp_n_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_max_finder
